instr_fetch: RTL and testbench
==============================

# instr_fetch

Parametrised prefetching instruction fetch unit for the 8-bit Z8-style processor. It replaces the processor's serial fetch/wait/read state sequence. Bytes stream from the synchronous program memory into a byte queue, and the unit decodes instruction length (1/2/3 bytes) from the opcode. Whole instructions are presented to the execute stage over a valid/ready handshake. A branch redirect flushes the queue and restarts fetching at the target.

## Interface
Parameters:
- ADDR_W, 8, program address width; fetch address wraps modulo 2^ADDR_W
- QUEUE_DEPTH, 4, byte queue entries; power of two, ≥ 3
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_addr  out  ADDR_W  fetch address (registered fetch pointer)
- mem_strobe  out  1  read request; memory returns data one cycle later
- mem_data  in  8  read data, valid the cycle after mem_strobe
- redirect_valid  in  1  branch taken; flush and refetch
- redirect_addr  in  ADDR_W  branch target
- instr_valid  out  1  complete instruction at queue head
- instr_ready  in  1  execute stage accepts
- instr_op  out  8  opcode byte
- instr_b2  out  8  second byte; 0 if len < 2
- instr_b3  out  8  third byte; 0 if len < 3
- instr_len  out  2  1, 2 or 3
- instr_pc  out  ADDR_W  address of opcode byte

## Operation
- Length decode on low nibble L of the head byte:
  - L = E or F → 1 byte
  - L = 4..7 or D → 3 bytes
  - otherwise → 2 bytes
- Fetch pointer fpc drives mem_addr. At most one read is in flight (flag `pend`).
- mem_strobe = ~redirect_valid & (count + pend < QUEUE_DEPTH). Each strobe increments fpc, wrapping to 0 past 2^ADDR_W−1.
- When `pend` is set and no flush occurs, mem_data is pushed at the queue tail in the cycle after the strobe.
- instr_valid = (count ≥ instr_len). Output fields come combinationally from the head entries.
- Handshake: an instruction is consumed on the edge where instr_valid & instr_ready. The queue pops instr_len bytes and instr_pc advances by instr_len, modulo 2^ADDR_W.
- Push and pop in the same cycle are both applied. The count update is count + push − len.
- redirect_valid, highest priority:
  - empties the queue and drops any in-flight return (pend cleared, mem_data ignored)
  - loads fpc and instr_pc with redirect_addr
  - ignores a concurrent consume
  - holds mem_strobe at 0 that cycle
- Queue full (count + pend = QUEUE_DEPTH): strobe is held low, fpc is held.
- Queue empty, or a partial instruction present: instr_valid is 0 and the instr_* fields are don't-care.

## Timing
- During reset:
  - fpc = instr_pc = RESET_PC
  - count = 0, pend = 0
  - mem_strobe = 0, instr_valid = 0
  - instr_* = 0 except instr_pc and instr_len
- Reset asserted mid-operation discards the queue and any in-flight read immediately.
- First strobe occurs in the first cycle after rst_n deasserts.
- Strobe at address A in cycle t → byte visible at queue in cycle t+2.
- 1-byte instruction: valid 2 cycles after its strobe. 3-byte instruction streamed from cycle t: valid at t+4.
- After a redirect in cycle r:
  - strobe to target in r+1
  - 1-byte target instruction valid in r+3
- Sustained fetch rate: 1 byte/cycle while the consumer keeps up.

## Structure
- Package `fetch_pkg`:
  - INSTR_LEN_1/2/3 constants
  - `instr_len_of(opcode)` function, shared with the processor decode
- Sub-module `byte_queue`:
  - circular buffer, push 1, pop 0..3
  - exposes head, head+1 and head+2 entries and count
  - pointers wrap modulo QUEUE_DEPTH
- `instr_fetch` holds fpc, pend, instr_pc, the strobe credit logic and the handshake.

## Test plan
- Reset release, memory 0x0F,0x0C,0x55,0xE6,0x12,0x34: ready held 1.
  - (0x0F, len 1, pc 0) then (0x0C 0x55, len 2, pc 1) then (0xE6 0x12 0x34, len 3, pc 3)
  - all in order, no duplicates or skips
- Backpressure, ready = 0 for 20 cycles: mem_strobe stops once count + pend = QUEUE_DEPTH, and fpc freezes. On release, the sequence continues without loss.
- Redirect to 0x40 in the same cycle as a consume with a read in flight:
  - the consume is ignored and the stale byte is dropped
  - next valid is instr_pc 0x40 exactly 2 cycles after the first strobe to 0x40
- ADDR_W = 8, instruction at 0xFE with length 3: bytes from 0xFE, 0xFF, 0x00. Next instr_pc is 0x01.
- Assert rst_n low mid-stream with 3 bytes queued: instr_valid drops asynchronously. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: instruction length constants and opcode length decode shared with the processor decode
package fetch_pkg;
  localparam logic [1:0] INSTR_LEN_1 = 2'd1;
  localparam logic [1:0] INSTR_LEN_2 = 2'd2;
  localparam logic [1:0] INSTR_LEN_3 = 2'd3;

  function automatic logic [1:0] instr_len_of(input logic [7:0] opcode);
    logic [3:0] lo;
    lo = opcode[3:0];
    return (lo >= 4'hE) ? INSTR_LEN_1
         : ((lo >= 4'h4 && lo <= 4'h7) || lo == 4'hD) ? INSTR_LEN_3
         : INSTR_LEN_2;
  endfunction
endpackage

// File: rtl/instr_fetch_byte_queue.sv
// byte_queue: circular byte buffer, one push and 0..3 pops per cycle, head three entries exposed
module byte_queue #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    pushData,
  input  logic [1:0]    popLen,
  output logic [7:0]    head0,
  output logic [7:0]    head1,
  output logic [7:0]    head2,
  output logic [CW-1:0] count
);
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] head, tail;

  assign head0 = mem[head];
  assign head1 = mem[head + PW'(1)];
  assign head2 = mem[head + PW'(2)];

  // storage is cleared on reset so the head fields read as zero while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= pushData;
        tail      <= tail + PW'(1);
      end
      head  <= head + PW'(popLen);
      count <= count + CW'(push) - CW'(popLen);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: prefetching fetch unit streaming program bytes into a queue and issuing whole instructions
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_strobe,
  input  logic [7:0]        mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_op,
  output logic [7:0]        instr_b2,
  output logic [7:0]        instr_b3,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [ADDR_W-1:0] fpc, instrPc;
  logic              pend, push, consume;
  logic [CW-1:0]     count;
  logic [7:0]        h0, h1, h2;

  // a strobe is only issued while the in-flight byte is guaranteed a free slot
  assign mem_strobe  = rst_n & ~redirect_valid & ((count + CW'(pend)) < CW'(QUEUE_DEPTH));
  assign push        = pend & ~redirect_valid;
  assign instr_len   = instr_len_of(h0);
  assign instr_valid = count >= CW'(instr_len);
  assign consume     = instr_valid & instr_ready & ~redirect_valid;
  assign instr_op    = h0;
  assign instr_b2    = (instr_len != INSTR_LEN_1) ? h1 : 8'h00;
  assign instr_b3    = (instr_len == INSTR_LEN_3) ? h2 : 8'h00;
  assign mem_addr    = fpc;
  assign instr_pc    = instrPc;

  byte_queue #(.DEPTH(QUEUE_DEPTH)) queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (push),
    .pushData (mem_data),
    .popLen   (consume ? instr_len : 2'd0),
    .head0    (h0),
    .head1    (h1),
    .head2    (h2),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc     <= RESET_PC;
      instrPc <= RESET_PC;
      pend    <= 1'b0;
    end else if (redirect_valid) begin
      fpc     <= redirect_addr;
      instrPc <= redirect_addr;
      pend    <= 1'b0;
    end else begin
      pend <= mem_strobe;
      if (mem_strobe) fpc <= fpc + ADDR_W'(1);
      if (consume) instrPc <= instrPc + ADDR_W'(instr_len);
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of streaming, backpressure, redirect, address wrap and async reset
module tb_instr_fetch;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_strobe;
  logic [7:0] mem_data = 8'h00;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_addr = 8'h00;
  logic       instr_valid;
  logic       instr_ready = 1'b1;
  logic [7:0] instr_op, instr_b2, instr_b3, instr_pc;
  logic [1:0] instr_len;
  logic [7:0] progMem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(8), .QUEUE_DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_strobe     (mem_strobe),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_op       (instr_op),
    .instr_b2       (instr_b2),
    .instr_b3       (instr_b3),
    .instr_len      (instr_len),
    .instr_pc       (instr_pc)
  );

  always @(posedge clk) if (mem_strobe) mem_data <= progMem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nextInstr(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic expectInstr(input string tag, input logic [7:0] op, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [1:0] len, input logic [7:0] pc);
    logic ok;
    nextInstr(20, ok);
    check({tag, "_valid"}, 32'(ok), 32'd1);
    if (ok) begin
      check({tag, "_op"}, 32'(instr_op), 32'(op));
      check({tag, "_b2"}, 32'(instr_b2), 32'(b2));
      check({tag, "_b3"}, 32'(instr_b3), 32'(b3));
      check({tag, "_len"}, 32'(instr_len), 32'(len));
      check({tag, "_pc"}, 32'(instr_pc), 32'(pc));
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) progMem[i] = 8'h0E;
    progMem[0] = 8'h0F; progMem[1] = 8'h0C; progMem[2] = 8'h55;
    progMem[3] = 8'hE6; progMem[4] = 8'h12; progMem[5] = 8'h34;
    for (int k = 0; k < 16; k++) progMem[8'h10 + k] = {4'(k), 4'hE};
    progMem[8'h40] = 8'h4E; progMem[8'h41] = 8'h5E;
    progMem[8'hFE] = 8'h04; progMem[8'hFF] = 8'hAA;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_strobe", 32'(mem_strobe), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", 32'(instr_pc), 32'h00);
    check("rst_addr", 32'(mem_addr), 32'h00);
    check("rst_op", 32'(instr_op), 32'h00);
    check("rst_b2", 32'(instr_b2), 32'h00);
    check("rst_b3", 32'(instr_b3), 32'h00);

    // stream from reset with ready held high
    rst_n = 1'b1;
    #1;
    check("first_strobe", 32'(mem_strobe), 32'd1);
    check("first_addr", 32'(mem_addr), 32'h00);
    @(negedge clk);
    check("c1_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("c2_valid", 32'(instr_valid), 32'd1);
    expectInstr("i0", 8'h0F, 8'h00, 8'h00, 2'd1, 8'h00);
    expectInstr("i1", 8'h0C, 8'h55, 8'h00, 2'd2, 8'h01);
    expectInstr("i2", 8'hE6, 8'h12, 8'h34, 2'd3, 8'h03);

    // backpressure at 0x10
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 8'h10;
    #1;
    check("bp_redir_strobe", 32'(mem_strobe), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("bp_first_addr", 32'(mem_addr), 32'h10);
    check("bp_first_strobe", 32'(mem_strobe), 32'd1);
    repeat (20) @(negedge clk);
    check("bp_strobe_stop", 32'(mem_strobe), 32'd0);
    check("bp_fpc_frozen", 32'(mem_addr), 32'h14);
    check("bp_valid", 32'(instr_valid), 32'd1);
    check("bp_pc", 32'(instr_pc), 32'h10);
    @(negedge clk);
    check("bp_fpc_still", 32'(mem_addr), 32'h14);
    instr_ready = 1'b1;
    for (int k = 0; k < 5; k++)
      expectInstr($sformatf("bp%0d", k), {4'(k), 4'hE}, 8'h00, 8'h00, 2'd1, 8'(8'h10 + k));

    // redirect colliding with a consume while a read is in flight
    check("pre_redir_valid", 32'(instr_valid), 32'd1);
    check("pre_redir_pc", 32'(instr_pc), 32'h15);
    redirect_valid = 1'b1;
    redirect_addr = 8'h40;
    #1;
    check("redir_strobe", 32'(mem_strobe), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("r1_valid", 32'(instr_valid), 32'd0);
    check("r1_strobe", 32'(mem_strobe), 32'd1);
    check("r1_addr", 32'(mem_addr), 32'h40);
    check("r1_pc", 32'(instr_pc), 32'h40);
    @(negedge clk);
    check("r2_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("r3_valid", 32'(instr_valid), 32'd1);
    expectInstr("t40", 8'h4E, 8'h00, 8'h00, 2'd1, 8'h40);
    expectInstr("t41", 8'h5E, 8'h00, 8'h00, 2'd1, 8'h41);

    // 3-byte instruction straddling the address wrap
    redirect_valid = 1'b1;
    redirect_addr = 8'hFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    expectInstr("wrap", 8'h04, 8'hAA, 8'h0F, 2'd3, 8'hFE);
    expectInstr("post_wrap", 8'h0C, 8'h55, 8'h00, 2'd2, 8'h01);

    // async reset with three bytes queued
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 8'h10;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_valid", 32'(instr_valid), 32'd1);
    check("mid_op", 32'(instr_op), 32'h0E);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_strobe", 32'(mem_strobe), 32'd0);
    check("arst_pc", 32'(instr_pc), 32'h00);
    check("arst_addr", 32'(mem_addr), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    #1;
    check("rel_addr", 32'(mem_addr), 32'h00);
    @(negedge clk);
    check("rel_c1_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    expectInstr("rel_i0", 8'h0F, 8'h00, 8'h00, 2'd1, 8'h00);
    expectInstr("rel_i1", 8'h0C, 8'h55, 8'h00, 2'd2, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
